control_matrix_core: RTL and testbench
======================================

# control_matrix_core

Minimal single-cycle soft-CPU execution core. Each clock it decodes a 24-bit command word and resolves two 8-bit operands, each either immediate or fetched from an external source. It then executes one ALU operation into an 8-bit accumulator (ACC) and advances an 8-bit instruction pointer. It sits between a command source (static/switch-driven word or instruction memory) and display/memory logic. ACC typically drives LEDs.

## Interface
Parameters: none.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  reset, synchronous and active-low.
- commandIn  input  24  command word, sampled every cycle.
- value1In  input  8  external data for operand 1; used only when addr flag 1 is set.
- value2In  input  8  external data for operand 2; used only when addr flag 2 is set.
- value1Out  output  8  resolved operand 1, combinational.
- value1Addy  output  8  operand-1 field `commandIn[16:9]`, combinational; this is the external address.
- value2Out  output  8  resolved operand 2, combinational.
- value2Addy  output  8  operand-2 field `commandIn[7:0]`, combinational.
- instructionPointer  output  8  registered instruction counter.
- ACC  output  8  registered accumulator.

## Operation
Command word fields:
- `[23:18]`: opcode.
- `[17]`: af1 (operand-1 address flag).
- `[16:9]`: f1 (operand-1 field).
- `[8]`: af2 (operand-2 address flag).
- `[7:0]`: f2 (operand-2 field).

Operand resolution, combinational:
- op1 = af1 ? value1In : f1.
- op2 = af2 ? value2In : f2.
- value1Out = op1; value2Out = op2.
- value1Addy = f1 and value2Addy = f2, regardless of the flags.

Opcodes. Result is written to ACC; all arithmetic is modulo 256 and carry/borrow are discarded.
- 000000 NOP: ACC unchanged.
- 000001 LDA: ACC ← op1.
- 000010 ADD: ACC ← op1 + op2.
- 000011 SUB: ACC ← op1 − op2 (two's complement wrap).
- 000100 AND: ACC ← op1 & op2.
- 000101 OR: ACC ← op1 | op2.
- 000110 XOR: ACC ← op1 ^ op2.
- 000111 ACCADD: ACC ← ACC + op1.
- 001000–111111: reserved, executed as NOP.

Instruction pointer:
- Increments by 1 every non-reset cycle, for every opcode including NOP and reserved.
- Wraps 255 → 0.

No status flags and no branches.

## Timing
- Reset: while reset_n is low at a rising edge, ACC = 0x00 and instructionPointer = 0x00. Reset dominates any opcode.
- Combinational outputs (value1Out/value2Out/value1Addy/value2Addy) track commandIn and value1In/value2In with no clock latency, including during reset.
- Execute latency is 1 cycle: the result for a command stable before edge N is visible on ACC after edge N.
- A static command re-executes every cycle:
  - ADD with constant operands holds a constant ACC.
  - ACCADD accumulates once per cycle.
- value1In/value2In must be valid in the same cycle as the command that flags them; the core provides no wait states.
- Reset deasserted mid-stream: the first edge with reset_n high executes the current command from ACC = 0, and IP becomes 1.

## Test plan
- Reset: hold reset_n = 0 for 2 cycles with command ADD 5,3 → ACC = 0x00, IP = 0x00. Release → after 1 edge ACC = 0x08, IP = 0x01.
- Immediate ADD with wrap: op 000010, af = 0/0, f1 = 0x15, f2 = 0xF0 → ACC = 0x05. value1Out = 0x15, value2Out = 0xF0.
- Address mode: ADD with af1 = 1, f1 = 0x40, value1In = 0x22, af2 = 0, f2 = 0x01:
  - value1Addy = 0x40, value1Out = 0x22.
  - ACC = 0x23 next edge.
  - Toggling value1In with af1 = 0 has no effect.
- SUB/logic: SUB 0x03,0x05 → 0xFE. AND 0xF0,0x3C → 0x30. OR → 0xFC. XOR → 0xCC. LDA 0x7E → 0x7E.
- ACCADD accumulation: ACC = 0 after reset, then ACCADD op1 = 0x10 held 17 cycles → ACC reads 0x10, 0x20, …, wraps to 0x10 at cycle 17.
- IP wrap and NOP/reserved: 256 cycles of NOP → IP returns to 0x00 and ACC is unchanged. An opcode of 0x3F leaves ACC unchanged and IP still increments.

Source files
------------

// File: rtl/control_matrix_core.sv
// control_matrix_core: single-cycle soft-CPU core; decodes a 24-bit command into one ALU op
// on an 8-bit accumulator and advances an 8-bit instruction pointer every cycle.
module control_matrix_core (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [23:0] commandIn,
    input  logic [7:0]  value1In,
    input  logic [7:0]  value2In,
    output logic [7:0]  value1Out,
    output logic [7:0]  value1Addy,
    output logic [7:0]  value2Out,
    output logic [7:0]  value2Addy,
    output logic [7:0]  instructionPointer,
    output logic [7:0]  ACC
);
    logic [5:0] w_opcode;
    logic       w_af1, w_af2;
    logic [7:0] w_f1, w_f2, w_op1, w_op2, w_next_acc;
    logic [7:0] r_acc, r_ip;

    assign w_opcode = commandIn[23:18];
    assign w_af1    = commandIn[17];
    assign w_f1     = commandIn[16:9];
    assign w_af2    = commandIn[8];
    assign w_f2     = commandIn[7:0];
    assign w_op1    = w_af1 ? value1In : w_f1;
    assign w_op2    = w_af2 ? value2In : w_f2;

    assign value1Out          = w_op1;
    assign value2Out          = w_op2;
    assign value1Addy         = w_f1;
    assign value2Addy         = w_f2;
    assign ACC                = r_acc;
    assign instructionPointer = r_ip;

    // Reserved opcodes fall through to the hold value, same as NOP.
    always_comb begin
        w_next_acc = (w_opcode == 6'd1) ? w_op1 :
                     (w_opcode == 6'd2) ? w_op1 + w_op2 :
                     (w_opcode == 6'd3) ? w_op1 - w_op2 :
                     (w_opcode == 6'd4) ? w_op1 & w_op2 :
                     (w_opcode == 6'd5) ? w_op1 | w_op2 :
                     (w_opcode == 6'd6) ? w_op1 ^ w_op2 :
                     (w_opcode == 6'd7) ? r_acc + w_op1 :
                     r_acc;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_acc <= 8'h00;
            r_ip  <= 8'h00;
        end else begin
            r_acc <= w_next_acc;
            r_ip  <= r_ip + 8'd1;
        end
    end
endmodule

// File: tb/tb_control_matrix_core.sv
// tb_control_matrix_core: directed and random stimulus checked against an integer
// reference model of the accumulator machine.
module tb_control_matrix_core;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] commandIn = '0;
    logic [7:0]  value1In = '0, value2In = '0;
    logic [7:0]  value1Out, value1Addy, value2Out, value2Addy, instructionPointer, ACC;

    int n_cmp = 0;
    int n_bad = 0;
    int m_acc = 0;
    int m_ip = 0;

    control_matrix_core dut (
        .clock(clock), .reset_n(reset_n), .commandIn(commandIn),
        .value1In(value1In), .value2In(value2In),
        .value1Out(value1Out), .value1Addy(value1Addy),
        .value2Out(value2Out), .value2Addy(value2Addy),
        .instructionPointer(instructionPointer), .ACC(ACC)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input int exp);
        logic [7:0] e;
        e = exp[7:0];
        n_cmp++;
        assert (obs === e) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    function automatic logic [23:0] mk(input int op, input int af1, input int f1, input int af2, input int f2);
        return 24'(op * 262144 + af1 * 131072 + f1 * 512 + af2 * 256 + f2);
    endfunction

    // Applies one command for one cycle, checking operands before the edge and state after it.
    task automatic step(input logic [23:0] cmd, input logic [7:0] v1, input logic [7:0] v2, input logic rn);
        int c, op, af1, f1, af2, f2, a, b;
        commandIn = cmd; value1In = v1; value2In = v2; reset_n = rn;
        #1;
        c = int'(cmd);
        op = c / 262144;
        af1 = (c / 131072) % 2;
        f1 = (c / 512) % 256;
        af2 = (c / 256) % 2;
        f2 = c % 256;
        a = af1 ? int'(v1) : f1;
        b = af2 ? int'(v2) : f2;
        chk("v1addy", value1Addy, f1);
        chk("v2addy", value2Addy, f2);
        chk("v1out", value1Out, a);
        chk("v2out", value2Out, b);
        @(posedge clock);
        #1;
        if (!rn) begin
            m_acc = 0;
            m_ip = 0;
        end else begin
            case (op)
                1: m_acc = a;
                2: m_acc = (a + b) % 256;
                3: m_acc = (a - b + 256) % 256;
                4: m_acc = a & b;
                5: m_acc = a | b;
                6: m_acc = a ^ b;
                7: m_acc = (m_acc + a) % 256;
                default: ;
            endcase
            m_ip = (m_ip + 1) % 256;
        end
        chk("acc", ACC, m_acc);
        chk("ip", instructionPointer, m_ip);
    endtask

    initial begin
        step(mk(2, 0, 5, 0, 3), 8'h00, 8'h00, 1'b0);
        step(mk(2, 0, 5, 0, 3), 8'h00, 8'h00, 1'b0);
        chk("rst_acc", ACC, 0);
        chk("rst_ip", instructionPointer, 0);
        step(mk(2, 0, 5, 0, 3), 8'h00, 8'h00, 1'b1);
        chk("rel_acc", ACC, 8'h08);
        chk("rel_ip", instructionPointer, 1);
        step(mk(2, 0, 8'h15, 0, 8'hF0), 8'hAA, 8'h55, 1'b1);
        chk("add_wrap", ACC, 8'h05);
        step(mk(2, 1, 8'h40, 0, 8'h01), 8'h22, 8'h99, 1'b1);
        chk("addr_add", ACC, 8'h23);
        step(mk(2, 0, 8'h40, 0, 8'h01), 8'h77, 8'h99, 1'b1);
        step(mk(2, 0, 8'h40, 0, 8'h01), 8'h13, 8'h99, 1'b1);
        chk("flag_off", ACC, 8'h41);
        step(mk(3, 0, 8'h03, 0, 8'h05), 8'h00, 8'h00, 1'b1);
        chk("sub", ACC, 8'hFE);
        step(mk(4, 0, 8'hF0, 0, 8'h3C), 8'h00, 8'h00, 1'b1);
        chk("and", ACC, 8'h30);
        step(mk(5, 0, 8'hF0, 0, 8'h3C), 8'h00, 8'h00, 1'b1);
        chk("or", ACC, 8'hFC);
        step(mk(6, 0, 8'hF0, 0, 8'h3C), 8'h00, 8'h00, 1'b1);
        chk("xor", ACC, 8'hCC);
        step(mk(1, 0, 8'h7E, 0, 8'h00), 8'h00, 8'h00, 1'b1);
        chk("lda", ACC, 8'h7E);
        step(mk(0, 0, 0, 0, 0), 8'h00, 8'h00, 1'b0);
        for (int i = 1; i <= 17; i++) begin
            step(mk(7, 0, 8'h10, 0, 8'h00), 8'h00, 8'h00, 1'b1);
            chk("accadd_seq", ACC, (i * 16) % 256);
        end
        for (int i = 0; i < 256; i++) step(mk(0, 0, i, 0, 255 - i), 8'h00, 8'h00, 1'b1);
        chk("nop_acc", ACC, 8'h10);
        step(mk(63, 1, 8'hFF, 1, 8'hFF), 8'h12, 8'h34, 1'b1);
        chk("rsvd_acc", ACC, 8'h10);
        for (int i = 0; i < 400; i++)
            step(24'($urandom), 8'($urandom), 8'($urandom), ($urandom_range(0, 19) != 0));
        for (int i = 0; i < 200; i++)
            step(mk($urandom_range(0, 8), $urandom_range(0, 1), $urandom_range(0, 255),
                    $urandom_range(0, 1), $urandom_range(0, 255)),
                 8'($urandom), 8'($urandom), 1'b1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
